// File: rtl/ps2_rx_fifo_if.sv
// Signal bundle between the PS/2 receiver and the memory-mapped PS2 register.
// The slave view is the receiver. The master view is the host side that drives the lines and the pop strobe.
interface ps2_rx_fifo_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic        ps2_ren;
  logic [15:0] ps2_data_out;
  logic        frame_err;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    input  ps2_ren,
    output ps2_data_out,
    output frame_err
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    output ps2_ren,
    input  ps2_data_out,
    input  frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a show-ahead scan-code FIFO.
// It checks start, odd parity and stop, times out stalled frames, and keeps a sticky overflow flag.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0] L_DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] L_TMO   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  state_t      r_state, w_state_next;
  logic [2:0]  r_bitcnt, w_bitcnt_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_par, w_par_next;
  logic        w_push, w_err, w_timeout;
  logic        r_frame_err;
  logic [TW-1:0] r_to_cnt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_nonempty, w_full, w_pop, w_push_ok, w_ovf_set;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= bus.ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= bus.ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == L_TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_frame_err <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bitcnt    <= w_bitcnt_next;
      r_shift     <= w_shift_next;
      r_par       <= w_par_next;
      r_frame_err <= w_err;
      if (r_state == S_IDLE || w_fall)
        r_to_cnt <= '0;
      else if (!w_timeout)
        r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_bitcnt_next = r_bitcnt;
    w_shift_next  = r_shift;
    w_par_next    = r_par;
    w_push        = 1'b0;
    w_err         = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            w_state_next  = S_DATA;
            w_bitcnt_next = 3'd0;
          end else begin
            w_err = 1'b1;
          end
        end
        S_DATA: begin
          w_shift_next[r_bitcnt] = r_dat_s2;
          if (r_bitcnt == 3'd7)
            w_state_next = S_PARITY;
          else
            w_bitcnt_next = r_bitcnt + 3'd1;
        end
        S_PARITY: begin
          w_par_next   = r_dat_s2;
          w_state_next = S_STOP;
        end
        S_STOP: begin
          w_state_next = S_IDLE;
          if (r_dat_s2 && (^{r_shift, r_par}))
            w_push = 1'b1;
          else
            w_err = 1'b1;
        end
        default: w_state_next = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next  = S_IDLE;
      w_bitcnt_next = 3'd0;
      w_err         = 1'b1;
    end
  end

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == L_DEPTH);
  assign w_pop      = bus.ps2_ren && w_nonempty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_ovf_set  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop)
        r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push_ok)
        r_count <= r_count - (AW+1)'(1);
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (bus.ps2_ren)
        r_ovf <= 1'b0;
    end
  end

  assign bus.ps2_data_out = {w_nonempty, r_ovf, 6'b000000,
                             w_nonempty ? r_mem[r_rd_ptr] : 8'h00};
  assign bus.frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed and randomized bench for ps2_rx_fifo.
// Expected words come from a queue-based model of received scan codes.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int HALF  = 8;

  logic clk;
  logic rst;
  ps2_rx_fifo_if bus();

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1)
      err_cnt <= err_cnt + 1;
  end

  logic [7:0] q[$];
  logic       ovf;

  function automatic logic [15:0] model_out();
    logic [7:0] h;
    h = (q.size() != 0) ? q[0] : 8'h00;
    return {(q.size() != 0) ? 1'b1 : 1'b0, ovf, 6'b000000, h};
  endfunction

  function automatic void model_push(input logic [7:0] b, input bit good);
    if (good) begin
      if (q.size() < DEPTH) q.push_back(b);
      else ovf = 1'b1;
    end
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] b, input bit flip, input bit stop);
    logic par;
    par = ~(^b) ^ flip;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-10s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ps2_fall(input logic v);
    bus.ps2_data = v;
    repeat (HALF) tick();
    bus.ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (HALF) tick();
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) ps2_rise();
      ps2_fall(f[i]);
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit flip, input bit stop);
    int e0;
    e0 = err_cnt;
    send_bits(mk(b, flip, stop), 11);
    ps2_rise();
    tick();
    model_push(b, !flip && stop);
    chk("ferr", 16'(err_cnt - e0), (!flip && stop) ? 16'd0 : 16'd1);
    chk("frame_out", bus.ps2_data_out, model_out());
  endtask

  task automatic pop();
    bus.ps2_ren = 1'b1;
    tick();
    bus.ps2_ren = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    ovf = 1'b0;
    chk("pop_out", bus.ps2_data_out, model_out());
  endtask

  initial begin
    int e0;
    logic [7:0] b;
    rst = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    bus.ps2_ren = 1'b0;
    ovf = 1'b0;
    repeat (3) tick();
    chk("rst_out", bus.ps2_data_out, 16'h0000);
    chk("rst_ferr", {15'd0, bus.frame_err}, 16'h0000);
    rst = 1'b0;
    tick();

    // Scan code 0x1C, checking push latency after the stop edge
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
    tick(); tick();
    chk("lat2", bus.ps2_data_out, 16'h0000);
    tick();
    chk("lat3", bus.ps2_data_out, 16'h801C);
    q.push_back(8'h1C);
    ps2_rise();
    pop();
    chk("t1_empty", bus.ps2_data_out, 16'h0000);

    // Bad parity then a good frame
    frame(8'h5A, 1'b1, 1'b1);
    chk("t2_bad", bus.ps2_data_out, 16'h0000);
    frame(8'hF0, 1'b0, 1'b1);
    chk("t2_good", bus.ps2_data_out, 16'h80F0);
    pop();

    // Overflow: nine frames into eight slots
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b1);
    chk("ovf_head", bus.ps2_data_out, 16'hC001);
    pop();
    chk("ovf_clr", bus.ps2_data_out, 16'h8002);
    for (int i = 0; i < 7; i++) pop();
    chk("ovf_end", bus.ps2_data_out, 16'h0000);

    // Timeout mid-frame
    e0 = err_cnt;
    send_bits(mk(8'h29, 1'b0, 1'b1), 5);
    ps2_rise();
    repeat (TMO + 40) tick();
    chk("tmo_ferr", 16'(err_cnt - e0), 16'd1);
    chk("tmo_out", bus.ps2_data_out, 16'h0000);
    frame(8'h29, 1'b0, 1'b1);
    chk("tmo_next", bus.ps2_data_out, 16'h8029);
    pop();

    // Full FIFO with a pop in the cycle the ninth stop bit is sampled
    for (int i = 0; i < DEPTH; i++) frame(8'($urandom_range(255)), 1'b0, 1'b1);
    b = 8'($urandom_range(255));
    send_bits(mk(b, 1'b0, 1'b1), 11);
    tick(); tick();
    bus.ps2_ren = 1'b1;
    tick();
    bus.ps2_ren = 1'b0;
    void'(q.pop_front());
    q.push_back(b);
    ovf = 1'b0;
    chk("sim_out", bus.ps2_data_out, model_out());
    chk("sim_ovf", {15'd0, bus.ps2_data_out[14]}, 16'h0000);
    ps2_rise();
    for (int i = 0; i < DEPTH; i++) pop();
    chk("sim_end", bus.ps2_data_out, 16'h0000);

    // Reset after the sixth falling edge
    e0 = err_cnt;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 6);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("mrst_out", bus.ps2_data_out, 16'h0000);
    chk("mrst_ferr", {15'd0, bus.frame_err}, 16'h0000);
    ps2_rise();
    repeat (3) tick();
    rst = 1'b0;
    q.delete();
    ovf = 1'b0;
    tick();
    chk("mrst_cnt", 16'(err_cnt - e0), 16'd0);
    frame(8'h1C, 1'b0, 1'b1);
    chk("mrst_next", bus.ps2_data_out, 16'h801C);
    pop();

    // Randomized frames, bad starts and pops against the model
    for (int it = 0; it < 30; it++) begin
      int kind;
      kind = int'($urandom_range(7));
      if (kind == 0) begin
        e0 = err_cnt;
        ps2_fall(1'b1);
        ps2_rise();
        tick();
        chk("rnd_bstart", 16'(err_cnt - e0), 16'd1);
      end else begin
        frame(8'($urandom_range(255)), kind == 1, kind != 2);
      end
      for (int k = int'($urandom_range(2)); k > 0; k--) pop();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 keyboard receiver that sits directly upstream of the memory block's PS2 register (0xF000). It synchronises the external PS/2 clock and data lines, deserialises 11-bit device-to-host frames, and checks parity and framing. Good scan codes are queued in a show-ahead FIFO. The memory block samples ps2_data_out on a read of 0xF000 and asserts ps2_ren in that same cycle, which pops the head entry.

Parameters:
FIFO_DEPTH, 8, number of queued scan codes; power of two, minimum 2.
TIMEOUT_CYCLES, 100000, clk cycles with no PS/2 falling edge mid-frame before the frame is abandoned (2 ms at 50 MHz).

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock line (asynchronous).
ps2_data  input  1  raw PS/2 data line (asynchronous).
ps2_ren  input  1  pop strobe from memory; one pop per cycle asserted.
ps2_data_out  output  16  status/data word, described under Behaviour.
frame_err  output  1  one-cycle pulse when a frame is discarded for a parity, start or stop error, or a timeout.

Behaviour:
- Reset: all state clears asynchronously. This covers the state machine (IDLE), bit counter, shift register, FIFO pointers and count, overflow flag and timeout counter. Synchroniser flops reset to 1 (idle line). Outputs reset to ps2_data_out=0x0000 and frame_err=0.
- Input sync: ps2_clk and ps2_data each pass through a 2-flop synchroniser. A falling edge is defined as the previous synced clk=1 and the current synced clk=0. The synced data bit is sampled in that cycle.
- Frame format: start bit (0), then 8 data bits LSB first, then an odd-parity bit (XOR of 8 data bits plus parity = 1), then a stop bit (1).
- State machine, advancing only on falling edges:
  - IDLE: on an edge with data=0, go to DATA with bitcnt=0. On an edge with data=1 (bad start), stay in IDLE and pulse frame_err.
  - DATA: shift the data bit into bit[bitcnt]. After bitcnt=7, go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: if stop=1 and parity is good, push the byte and go to IDLE. Otherwise, pulse frame_err, push nothing, and go to IDLE.
- Timeout: the counter runs while the state is not IDLE and clears on every falling edge. When it reaches TIMEOUT_CYCLES, go to IDLE, clear bitcnt, and pulse frame_err.
- Push latency: the FIFO write occurs on the clk edge that samples the stop bit. ps2_data_out reflects the new entry from the next cycle, which is 3 clk cycles after the raw 11th falling edge.
- ps2_data_out is combinational from registered state (show-ahead):
  - bit 15: FIFO non-empty.
  - bit 14: sticky overflow flag.
  - bits 13:8: zero.
  - bits 7:0: head byte, or 0x00 when empty.
- Pop: when ps2_ren=1 and the FIFO is non-empty, the read pointer advances at that edge. ps2_ren on an empty FIFO has no effect on the pointers.
- Overflow:
  - A push while the FIFO is full and no pop occurs in the same cycle drops the new byte and sets overflow. The oldest entries are retained.
  - The overflow flag clears on any cycle with ps2_ren=1. If a set and a clear occur in the same cycle, set wins.
- Simultaneous push and pop: both take effect and the count is unchanged. When full, push and pop together is accepted with no overflow. When empty, the push proceeds and the pop is ignored.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-frame: the partial frame is lost, with no push and no frame_err. The next start bit begins a fresh frame.
- frame_err is registered and is high for exactly one clk per failed frame.

Test Plan:
- Send scan code 0x1C with correct parity (parity bit 0) -> 3 clks after the stop edge, ps2_data_out=0x801C. Pulse ps2_ren for 1 cycle -> ps2_data_out=0x0000 the next cycle.
- Send 0x5A with an inverted parity bit -> frame_err high for exactly 1 clk, ps2_data_out remains 0x0000. A following correct 0xF0 frame -> 0x80F0.
- Send 9 frames (0x01..0x09) with no reads, depth 8 -> ps2_data_out=0xC001. Eight single-cycle pops return 0x01..0x08 in order. Bit 14 clears after the first pop. After the eighth pop, the output is 0x0000; 0x09 is absent.
- Send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses once. A complete 0x29 frame then yields 0x8029.
- FIFO full (8 entries) with ps2_ren asserted in the exact cycle the 9th stop bit is sampled -> no overflow (bit 14=0), count stays 8, the head advances to the 2nd entry, and the 9th byte is read last.
- Assert rst after the 6th falling edge of a frame -> outputs 0x0000 and frame_err=0. The next full frame 0x1C is received correctly as 0x801C.
